// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
package pipe_ctrl_pkg;

  localparam int unsigned DEF_REG_ADDR_W = 3;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with asynchronous active-low clear.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline register sequencing: load-use stalls, branch flushes, data-memory wait freeze
// with timeout, plus saturating stall/flush counters for performance debug.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W  = DEF_REG_ADDR_W,
  parameter bit          ZERO_REG_HW = 1'b1,
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_rf_wr_en,
  input  logic                  ex_br_taken,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  output logic                  pc_en,
  output logic                  if_id_en,
  output logic                  if_id_flush,
  output logic                  id_ex_en,
  output logic                  id_ex_bubble,
  output logic                  ex_mem_en,
  output logic                  mem_wb_bubble,
  output logic                  mem_error,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

  ctrl_state_t       r_state;
  ctrl_state_t       w_next_state;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] w_next_wait;
  logic              r_mem_error;
  logic              w_next_err;

  logic w_rs1_match;
  logic w_rs2_match;
  logic w_rd_valid;
  logic w_lu_hazard;
  logic w_freeze;
  logic w_apply;
  logic w_err_out;
  logic w_branch;
  logic w_lu_stall;

  // A write to hardwired r0 is never a real producer.
  assign w_rs1_match = id_use_rs1 && (id_rs1 == ex_rd);
  assign w_rs2_match = id_use_rs2 && (id_rs2 == ex_rd);
  assign w_rd_valid  = !(ZERO_REG_HW && (ex_rd == '0));
  assign w_lu_hazard = ex_mem_read && ex_rf_wr_en && w_rd_valid && (w_rs1_match || w_rs2_match);

  always_comb begin
    w_next_state = r_state;
    w_next_wait  = r_wait_cnt;
    w_next_err   = r_mem_error;
    w_freeze     = 1'b0;
    w_apply      = 1'b0;
    w_err_out    = 1'b0;
    case (r_state)
      RUN: begin
        if (mem_req && !mem_ready) begin
          w_freeze     = 1'b1;
          w_next_state = MEM_WAIT;
          w_next_wait  = WAIT_W'(1);
        end else begin
          w_apply = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (!mem_ready) begin
          w_freeze = 1'b1;
          if (r_wait_cnt == WAIT_W'(MEM_TIMEOUT)) begin
            w_next_state = ERROR;
            w_next_err   = 1'b1;
          end else begin
            w_next_wait = r_wait_cnt + WAIT_W'(1);
          end
        end else begin
          // Release cycle: the memory request is not re-evaluated here.
          w_apply      = 1'b1;
          w_next_state = RUN;
          w_next_wait  = '0;
        end
      end
      default: begin
        w_err_out    = 1'b1;
        w_next_state = ERROR;
      end
    endcase
  end

  // A taken branch squashes the ID instruction, so its hazard is moot.
  assign w_branch   = w_apply && ex_br_taken;
  assign w_lu_stall = w_apply && !ex_br_taken && w_lu_hazard;

  always_comb begin
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_en      = 1'b1;
    id_ex_bubble  = 1'b0;
    ex_mem_en     = 1'b1;
    mem_wb_bubble = 1'b0;
    if (!rst || w_err_out) begin
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_en      = 1'b0;
      id_ex_bubble  = 1'b1;
      ex_mem_en     = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (w_freeze) begin
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      id_ex_en      = 1'b0;
      ex_mem_en     = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (w_branch) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (w_lu_stall) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= RUN;
      r_wait_cnt  <= '0;
      r_mem_error <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_wait_cnt  <= w_next_wait;
      r_mem_error <= w_next_err;
    end
  end

  assign mem_error = r_mem_error;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clr_n (rst),
    .inc   (!pc_en),
    .q     (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clr_n (rst),
    .inc   (w_branch),
    .q     (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: single-cycle vector table plus memory-wait,
// timeout, reset and counter-saturation sequences.
module tb_pipeline_hazard_ctrl;

  // Output bundle order: {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en, mem_wb_bubble}
  localparam logic [6:0] NORM   = 7'b1101010;
  localparam logic [6:0] STALL  = 7'b0001110;
  localparam logic [6:0] BR     = 7'b1111110;
  localparam logic [6:0] FREEZE = 7'b0000001;
  localparam logic [6:0] HALT   = 7'b0010101;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs1, id_use_rs2, ex_mem_read, ex_rf_wr_en, ex_br_taken, mem_req, mem_ready;
  logic       pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en, mem_wb_bubble, mem_error;
  logic [15:0] stall_cnt, flush_cnt;
  logic       s_pc_en, s_if_id_en, s_if_id_flush, s_id_ex_en, s_id_ex_bubble, s_ex_mem_en;
  logic       s_mem_wb_bubble, s_mem_error;
  logic [3:0] s_stall_cnt, s_flush_cnt;

  int errors = 0;
  int checks = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  typedef struct packed {
    logic [2:0] rs1;
    logic [2:0] rs2;
    logic       u1;
    logic       u2;
    logic [2:0] rd;
    logic       mr;
    logic       wr;
    logic       br;
    logic       mreq;
    logic       mrdy;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs [12];

  always #5 clk = ~clk;

  pipeline_hazard_ctrl u_dut (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
    .id_use_rs2(id_use_rs2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_rf_wr_en(ex_rf_wr_en),
    .ex_br_taken(ex_br_taken), .mem_req(mem_req), .mem_ready(mem_ready), .pc_en(pc_en),
    .if_id_en(if_id_en), .if_id_flush(if_id_flush), .id_ex_en(id_ex_en), .id_ex_bubble(id_ex_bubble),
    .ex_mem_en(ex_mem_en), .mem_wb_bubble(mem_wb_bubble), .mem_error(mem_error),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipeline_hazard_ctrl #(.CNT_W(4)) u_small (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
    .id_use_rs2(id_use_rs2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_rf_wr_en(ex_rf_wr_en),
    .ex_br_taken(ex_br_taken), .mem_req(mem_req), .mem_ready(mem_ready), .pc_en(s_pc_en),
    .if_id_en(s_if_id_en), .if_id_flush(s_if_id_flush), .id_ex_en(s_id_ex_en),
    .id_ex_bubble(s_id_ex_bubble), .ex_mem_en(s_ex_mem_en), .mem_wb_bubble(s_mem_wb_bubble),
    .mem_error(s_mem_error), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  function automatic logic [6:0] outs();
    return {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en, mem_wb_bubble};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    id_rs1 = 3'd0; id_rs2 = 3'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_rd = 3'd0;
    ex_mem_read = 1'b0; ex_rf_wr_en = 1'b0; ex_br_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic set_lu();
    id_rs1 = 3'd3; id_use_rs1 = 1'b1; ex_rd = 3'd3; ex_mem_read = 1'b1; ex_rf_wr_en = 1'b1;
  endtask

  task automatic apply(input vec_t v);
    id_rs1 = v.rs1; id_rs2 = v.rs2; id_use_rs1 = v.u1; id_use_rs2 = v.u2; ex_rd = v.rd;
    ex_mem_read = v.mr; ex_rf_wr_en = v.wr; ex_br_taken = v.br; mem_req = v.mreq; mem_ready = v.mrdy;
  endtask

  task automatic chk_cnts(input string name);
    chk({name, "_stall"}, 32'(stall_cnt), 32'(exp_stall));
    chk({name, "_flush"}, 32'(flush_cnt), 32'(exp_flush));
  endtask

  initial begin
    //          rs1   rs2   u1    u2    rd    mr    wr    br    mreq  mrdy  exp
    vecs[0]  = '{3'd3, 3'd0, 1'b1, 1'b0, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, STALL};
    vecs[1]  = '{3'd0, 3'd0, 1'b1, 1'b1, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, NORM};
    vecs[2]  = '{3'd3, 3'd0, 1'b0, 1'b0, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, NORM};
    vecs[3]  = '{3'd1, 3'd5, 1'b1, 1'b1, 3'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, STALL};
    vecs[4]  = '{3'd3, 3'd0, 1'b1, 1'b0, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, NORM};
    vecs[5]  = '{3'd3, 3'd0, 1'b1, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, NORM};
    vecs[6]  = '{3'd3, 3'd0, 1'b1, 1'b0, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, BR};
    vecs[7]  = '{3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, BR};
    vecs[8]  = '{3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, NORM};
    vecs[9]  = '{3'd4, 3'd0, 1'b1, 1'b0, 3'd4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, STALL};
    vecs[10] = '{3'd2, 3'd6, 1'b1, 1'b1, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, NORM};
    vecs[11] = '{3'd7, 3'd7, 1'b0, 1'b1, 3'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, STALL};

    // Reset values
    idle();
    rst = 1'b0;
    #12;
    chk("reset_outs", 32'(outs()), 32'(HALT));
    chk("reset_err", 32'(mem_error), 32'd0);
    chk_cnts("reset");
    @(negedge clk);
    rst = 1'b1;
    #1 chk("post_reset_norm", 32'(outs()), 32'(NORM));

    // Single-cycle events in RUN
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      apply(vecs[i]);
      #1 chk($sformatf("vec%0d_outs", i), 32'(outs()), 32'(vecs[i].exp));
      if (vecs[i].exp[6] == 1'b0) exp_stall++;
      if (vecs[i].exp == BR) exp_flush++;
      @(posedge clk);
      #1 chk_cnts($sformatf("vec%0d", i));
    end

    // Three frozen cycles, release on the fourth
    @(negedge clk); idle(); mem_req = 1'b1;
    #1 chk("wait_c1", 32'(outs()), 32'(FREEZE));
    @(negedge clk); mem_req = 1'b0;
    #1 chk("wait_c2", 32'(outs()), 32'(FREEZE));
    @(negedge clk);
    #1 chk("wait_c3", 32'(outs()), 32'(FREEZE));
    @(negedge clk); mem_ready = 1'b1;
    #1 chk("wait_release", 32'(outs()), 32'(NORM));
    exp_stall += 3;
    @(posedge clk);
    #1 chk_cnts("wait3");
    @(negedge clk); idle();
    #1 chk("wait_back_run", 32'(outs()), 32'(NORM));

    // Release cycle with branch plus hazard
    @(negedge clk); mem_req = 1'b1;
    #1 chk("wbr_freeze", 32'(outs()), 32'(FREEZE));
    @(negedge clk); mem_req = 1'b0; mem_ready = 1'b1; ex_br_taken = 1'b1; set_lu();
    #1 chk("wbr_release", 32'(outs()), 32'(BR));
    exp_stall += 1; exp_flush += 1;
    @(posedge clk);
    #1 chk_cnts("wbr");

    // Release cycle with load-use hazard
    @(negedge clk); idle(); mem_req = 1'b1;
    #1 chk("wlu_freeze", 32'(outs()), 32'(FREEZE));
    @(negedge clk); mem_req = 1'b0; mem_ready = 1'b1; set_lu();
    #1 chk("wlu_release", 32'(outs()), 32'(STALL));
    exp_stall += 2;
    @(posedge clk);
    #1 chk_cnts("wlu");

    // Timeout: 1 RUN freeze + 15 MEM_WAIT cycles, then ERROR
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) begin idle(); mem_req = 1'b1; end
      #1 chk($sformatf("tmo_c%0d_outs", k), 32'(outs()), 32'((k <= 16) ? FREEZE : HALT));
      chk($sformatf("tmo_c%0d_err", k), 32'(mem_error), 32'(k >= 17));
    end
    exp_stall += 20;
    @(posedge clk);
    #1 chk_cnts("tmo");
    @(negedge clk); mem_ready = 1'b1; mem_req = 1'b0;
    #1 chk("err_sticky_outs", 32'(outs()), 32'(HALT));
    chk("err_sticky_flag", 32'(mem_error), 32'd1);

    // Asynchronous reset from ERROR
    #2 rst = 1'b0;
    #1 chk("err_rst_outs", 32'(outs()), 32'(HALT));
    chk("err_rst_flag", 32'(mem_error), 32'd0);
    exp_stall = 0; exp_flush = 0;
    chk_cnts("err_rst");
    @(negedge clk); rst = 1'b1; idle();
    #1 chk("err_rst_run", 32'(outs()), 32'(NORM));

    // Reset mid-wait leaves no residual freeze
    @(negedge clk); mem_req = 1'b1;
    @(negedge clk); mem_req = 1'b0;
    #1 chk("midwait_frozen", 32'(outs()), 32'(FREEZE));
    rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    #1 chk("midwait_rst_run", 32'(outs()), 32'(NORM));
    chk_cnts("midwait_rst");

    // Twenty load-use stalls: 4-bit counter saturates at 15
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); set_lu();
      #1 if (k == 0) chk("sat_stall_outs", 32'(outs()), 32'(STALL));
    end
    @(posedge clk);
    #1 chk("sat_small_stall", 32'(s_stall_cnt), 32'd15);
    chk("sat_small_flush", 32'(s_flush_cnt), 32'd0);
    chk("sat_main_stall", 32'(stall_cnt), 32'd20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
